memory_interface: RTL and testbench

- Memory-side bus interface between the CPU datapath bus and the 512x32 synchronous RAM.
- Owns the MAR and MDR registers and sequences RAM read/write strobes with a small FSM.
- Hides the RAM's one-cycle registered read latency. Issues a single-cycle done pulse so the control unit can advance.
- Sits directly upstream of the RAM: drives its address, read, write and data-in; consumes its data-out.

---
 rtl/memory_interface.sv | 121 ++++++++++++
 tb/tb_memory_interface.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_interface.sv
// Memory-side bus interface: owns MAR/MDR and sequences RAM read/write strobes.
// Optional address bounds checking is enabled with `define MEM_BOUNDS_CHECK_EN.
module memory_interface #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  mar_in,
  input  logic                  mdr_in,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mar_q,
  output logic [DATA_WIDTH-1:0] mdr_q,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAP   = 3'd2,
    WR_ISSUE = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state;
  logic   upper_set;
  logic   err_next;

  assign ram_address = mar_q;
  assign ram_wdata   = mdr_q;
  assign upper_set   = |bus_in[DATA_WIDTH-1:ADDR_WIDTH];

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_q;

  // A same-cycle MAR load decides whether the accompanying request is rejected.
  always_comb begin
    err_next = err_q;
    if (state == IDLE && mar_in) err_next = upper_set;
  end

  assign addr_err = err_q;
`else
  logic unused_upper;

  assign unused_upper = upper_set;
  assign err_next     = 1'b0;
  assign addr_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state     <= IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q     <= err_next;
`endif
      case (state)
        IDLE: begin
          if (mar_in) mar_q <= bus_in[ADDR_WIDTH-1:0];
          if (mdr_in) mdr_q <= bus_in;
          if (mem_read || mem_write) begin
            busy <= 1'b1;
            if (err_next) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (mem_read) begin
              // Read has priority; a simultaneous write is dropped.
              state    <= RD_ISSUE;
              ram_read <= 1'b1;
            end else begin
              state     <= WR_ISSUE;
              ram_write <= 1'b1;
            end
          end
        end
        RD_ISSUE: state <= RD_CAP;
        RD_CAP: begin
          // RAM data registered on the RD_ISSUE edge is valid now.
          mdr_q <= ram_rdata;
          state <= DONE;
          done  <= 1'b1;
        end
        WR_ISSUE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_interface.sv
// Self-checking bench for memory_interface with an attached 512x32 RAM model
// and a transaction-level reference memory.
module tb_memory_interface;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] bus_in;
  logic        mar_in, mdr_in, mem_read, mem_write;
  logic [8:0]  mar_q;
  logic [31:0] mdr_q;
  logic        busy, done, addr_err;
  logic [8:0]  ram_address;
  logic        ram_read, ram_write;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] ram     [0:511];
  logic [31:0] ref_mem [0:511];

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, both_cnt = 0;

  memory_interface #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
    .clk(clk), .clr_n(clr_n), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .mem_read(mem_read), .mem_write(mem_write), .mar_q(mar_q), .mdr_q(mdr_q),
    .busy(busy), .done(done), .addr_err(addr_err), .ram_address(ram_address),
    .ram_read(ram_read), .ram_write(ram_write), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read, plus strobe/done counters
  always @(posedge clk) begin
    if (ram_write === 1'b1) ram[ram_address] <= ram_wdata;
    if (ram_read === 1'b1) ram_rdata <= ram[ram_address];
    if (ram_read === 1'b1) rd_cnt <= rd_cnt + 1;
    if (ram_write === 1'b1) wr_cnt <= wr_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (ram_read === 1'b1 && ram_write === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mar_in = 1'b0; mdr_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic run_read(input logic [31:0] a, input bit also_write, input bit inject);
    logic [8:0]  ea;
    logic [31:0] exp_d;
    int r0, w0, d0;
    ea = a[8:0];
    exp_d = ref_mem[ea];
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    bus_in = a; mar_in = 1'b1; mem_read = 1'b1; mem_write = also_write;
    tick();  // E0
    idle_inputs();
    checks++; if (ram_read !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rd_issue: ram_read=%b busy=%b exp 1 1", ram_read, busy); end
    checks++; if (ram_address !== ea) begin errors++; $display("FAIL rd_addr: got %h exp %h", ram_address, ea); end
    if (inject) begin
      bus_in = 32'h0000_0055; mar_in = 1'b1; mdr_in = 1'b1; mem_write = 1'b1;
    end
    tick();  // E1
    checks++; if (ram_read !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_cap: ram_read=%b done=%b busy=%b exp 0 0 1", ram_read, done, busy); end
    tick();  // E2
    checks++; if (mdr_q !== exp_d) begin errors++; $display("FAIL rd_data @%h: got %h exp %h", ea, mdr_q, exp_d); end
    checks++; if (done !== 1'b1 || mar_q !== ea) begin errors++; $display("FAIL rd_done: done=%b mar=%h exp 1 %h", done, mar_q, ea); end
    tick();  // E3
    idle_inputs();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_end: done=%b busy=%b exp 0 0", done, busy); end
    checks++; if (rd_cnt - r0 != 1 || wr_cnt - w0 != 0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL rd_counts: rd=%0d wr=%0d done=%0d exp 1 0 1", rd_cnt - r0, wr_cnt - w0, done_cnt - d0);
    end
    if (inject) begin
      checks++; if (mar_q !== ea || mdr_q !== exp_d) begin errors++; $display("FAIL busy_reject: mar=%h mdr=%h exp %h %h", mar_q, mdr_q, ea, exp_d); end
    end
  endtask

  task automatic run_write(input logic [8:0] a, input logic [31:0] d, input bit mar_last);
    int r0, w0, d0;
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    if (mar_last) begin
      bus_in = d; mdr_in = 1'b1;
      tick();
      idle_inputs();
      bus_in = {23'd0, a}; mar_in = 1'b1; mem_write = 1'b1;
    end else begin
      bus_in = {23'd0, a}; mar_in = 1'b1;
      tick();
      idle_inputs();
      bus_in = d; mdr_in = 1'b1; mem_write = 1'b1;
    end
    tick();  // E0
    idle_inputs();
    checks++; if (ram_write !== 1'b1 || ram_read !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL wr_issue: wr=%b rd=%b done=%b exp 1 0 0", ram_write, ram_read, done); end
    checks++; if (ram_address !== a || ram_wdata !== d) begin errors++; $display("FAIL wr_bus: addr=%h data=%h exp %h %h", ram_address, ram_wdata, a, d); end
    ref_mem[a] = d;
    tick();  // E1
    checks++; if (done !== 1'b1 || ram_write !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_done: done=%b wr=%b busy=%b exp 1 0 1", done, ram_write, busy); end
    tick();  // E2
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_end: done=%b busy=%b exp 0 0", done, busy); end
    checks++; if (wr_cnt - w0 != 1 || rd_cnt - r0 != 0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL wr_counts: wr=%0d rd=%0d done=%0d exp 1 0 1", wr_cnt - w0, rd_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    int d0, r1;
    clr_n = 1'b0; idle_inputs(); bus_in = '0;
    tick(); tick();
    checks++; if ({busy, done, addr_err, ram_read, ram_write} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 00000", {busy, done, addr_err, ram_read, ram_write}); end
    checks++; if (mar_q !== 9'd0 || mdr_q !== 32'd0) begin errors++; $display("FAIL reset_regs: mar=%h mdr=%h exp 0 0", mar_q, mdr_q); end
    clr_n = 1'b1;
    bus_in = 32'h12; mar_in = 1'b1;
    tick();
    idle_inputs();
    bus_in = $urandom | 32'h1; mdr_in = 1'b1; mem_read = 1'b1;
    tick();  // accepted, now in RD_ISSUE
    idle_inputs();
    checks++; if (ram_read !== 1'b1) begin errors++; $display("FAIL rst_pre: ram_read=%b exp 1", ram_read); end
    d0 = done_cnt;
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    checks++; if ({busy, done, ram_read, ram_write} !== 4'b0 || mar_q !== 9'd0 || mdr_q !== 32'd0) begin
      errors++; $display("FAIL rst_abort: ctrl=%b mar=%h mdr=%h exp 0000 0 0", {busy, done, ram_read, ram_write}, mar_q, mdr_q);
    end
    r1 = rd_cnt;
    tick(); tick(); tick();
    checks++; if (mdr_q !== 32'd0 || done_cnt != d0 || rd_cnt != r1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_quiet: mdr=%h done_delta=%0d rd_delta=%0d busy=%b exp 0 0 0 0", mdr_q, done_cnt - d0, rd_cnt - r1, busy);
    end
  endtask

  task automatic test_read();
    run_read(32'h12, 1'b0, 1'b0);
  endtask

  task automatic test_write();
    run_write(9'h1FF, 32'hCAFEF00D, 1'b0);
    run_read(32'h1FF, 1'b0, 1'b0);
    checks++; if (mdr_q !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_readback: got %h exp cafef00d", mdr_q); end
  endtask

  task automatic test_busy_reject();
    run_read(32'h12, 1'b0, 1'b1);
  endtask

  task automatic test_simultaneous();
    logic [8:0] a;
    a = 9'($urandom_range(0, 511));
    run_read({23'd0, a}, 1'b1, 1'b0);
    checks++; if (ram[a] !== ref_mem[a]) begin errors++; $display("FAIL simul_nowrite: ram=%h exp %h", ram[a], ref_mem[a]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1)
        run_write(9'($urandom_range(0, 511)), $urandom, 1'($urandom_range(0, 1)));
      else
        run_read({23'd0, 9'($urandom_range(0, 511))}, 1'b0, 1'b0);
    end
  endtask

  task automatic test_bounds();
`ifdef MEM_BOUNDS_CHECK_EN
    logic [31:0] m0;
    int r0, d0;
    bus_in = 32'h0000_0200; mar_in = 1'b1;
    tick();
    idle_inputs();
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL bounds_set: addr_err=%b exp 1", addr_err); end
    m0 = mdr_q; r0 = rd_cnt; d0 = done_cnt;
    mem_read = 1'b1;
    tick();
    idle_inputs();
    checks++; if (ram_read !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bounds_req: rd=%b done=%b busy=%b exp 0 1 1", ram_read, done, busy); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || mdr_q !== m0 || rd_cnt != r0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL bounds_end: done=%b busy=%b mdr=%h rd_delta=%0d exp 0 0 %h 0", done, busy, mdr_q, rd_cnt - r0, m0);
    end
    bus_in = 32'h10; mar_in = 1'b1;
    tick();
    idle_inputs();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL bounds_clear: addr_err=%b exp 0", addr_err); end
    run_read(32'h10, 1'b0, 1'b0);
`else
    bus_in = 32'h0000_0200; mar_in = 1'b1;
    tick();
    idle_inputs();
    checks++; if (addr_err !== 1'b0 || mar_q !== 9'd0) begin errors++; $display("FAIL trunc_load: addr_err=%b mar=%h exp 0 0", addr_err, mar_q); end
    run_read(32'h0000_0200, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_strobe_exclusive();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles exp 0", both_cnt); end
  endtask

  initial begin
    clr_n = 1'b0; bus_in = '0;
    idle_inputs();
    for (int i = 0; i < 512; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[9'h012] = 32'hDEADBEEF;
    ref_mem[9'h012] = 32'hDEADBEEF;
    test_reset();
    test_read();
    test_write();
    test_busy_reject();
    test_simultaneous();
    test_random();
    test_bounds();
    test_strobe_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
